decoder_pipe: RTL and testbench
===============================

DECODER_PIPE -- requirements
Module: decoder_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the operand output width (legal range 8..32).
REQ-002 SHALL have parameter SIGN_EXT, default 0, meaning the 8-bit operand fields are zero-extended (0) or sign-extended (1) to DATA_W.
REQ-003 SHALL have parameter DEPTH, default 2, meaning the output queue entry count (power of 2, at least 2).
REQ-004 SHALL have parameter DROP_NOP, default 1, meaning `INSTRUCTION_NOP is consumed without being enqueued (1) or is enqueued (0).
REQ-005 SHALL have parameter CNT_W, default 16, meaning the width of the decoded-instruction counter.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port in_valid, input, 1 bit: instruction is presented.
REQ-009 SHALL have port in_ready, output, 1 bit: the block can accept an instruction.
REQ-010 SHALL have port instruction, input, 32 bits: opcode [31:16], A field [15:8], B field [7:0].
REQ-011 SHALL have port out_valid, output, 1 bit: the queue head holds a decoded entry.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the head entry.
REQ-013 SHALL have ports op1 and op2, outputs, DATA_W bits each: the head entry's operands.
REQ-014 SHALL have port opsel, output, 3 bits: the head entry's ALU select (`OPSEL_* encoding).
REQ-015 SHALL have port illegal, output, 1 bit: the head entry carried an unrecognised opcode.
REQ-016 SHALL have port decoded_cnt, output, CNT_W bits: number of entries popped since reset.

Function
REQ-017 Accept: an instruction transfers when in_valid=1 and in_ready=1; in_ready=1 exactly when the queue is not full, with no same-cycle pop bypass.
REQ-018 Pop: an entry transfers when out_valid=1 and out_ready=1; the head advances at that edge.
REQ-019 Decode mapping: AND/OR/XOR/ADD/SUB set op1=ext(A), op2=ext(B), opsel=matching `OPSEL_*, illegal=0.
REQ-020 Decode mapping: NEG sets op1=ext(A), op2=0, opsel=`OPSEL_NEG, illegal=0.
REQ-021 Decode mapping: NOP sets op1=0, op2=0, opsel=`OPSEL_NONE, illegal=0; when DROP_NOP=1 it is accepted and discarded, with no enqueue.
REQ-022 Decode mapping: any other opcode sets op1=0, op2=0, opsel=`OPSEL_NONE, illegal=1, and is always enqueued.
REQ-023 ext(): zero-extension when SIGN_EXT=0; when SIGN_EXT=1 bit 7 is replicated into bits [DATA_W-1:8]; with DATA_W=8 the field passes through unchanged.
REQ-024 No output bit is ever X; every decoded field is fully defined.
REQ-025 Latency: an instruction accepted at edge N into an empty queue is presented with out_valid=1 after edge N, i.e. visible in cycle N+1.
REQ-026 Ordering: entries are delivered strictly in acceptance order.
REQ-027 Queue pointers: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-028 Queue occupancy: full and empty are tracked by an occupancy count of 0..DEPTH.
REQ-029 Simultaneous push and pop on a non-full, non-empty queue leaves occupancy unchanged.
REQ-030 Pop when empty has no effect.
REQ-031 decoded_cnt increments by 1 on each pop, illegal entries included, and wraps from 2^CNT_W-1 to 0.
REQ-032 op1, op2, opsel and illegal hold their last values while out_valid=0.

Reset
REQ-033 On rst_n=0 the block SHALL immediately reach: in_ready=0, out_valid=0, op1=0, op2=0, opsel=`OPSEL_NONE, illegal=0, decoded_cnt=0, pointers=0, occupancy=0.
REQ-034 Reset asserted mid-operation SHALL discard all queued entries; no pop is counted for them.
REQ-035 in_ready SHALL rise in the first cycle after rst_n deasserts.

Verification
REQ-036 ADD 0x12,0x34 with out_ready=1 -> next cycle: out_valid=1, op1=0x00000012, op2=0x00000034, opsel=`OPSEL_ADD; decoded_cnt=1 after the pop.
REQ-037 SIGN_EXT=1: SUB 0x80,0x7F -> op1=0xFFFFFF80, op2=0x0000007F; NEG 0xFF -> op1=0xFFFFFFFF, op2=0.
REQ-038 DEPTH=2, out_ready=0: push 3 ADDs back to back -> in_ready=0 after the second; raise out_ready -> delivered in order, in_ready=1 after the first pop.
REQ-039 Opcode 0xFFFF, then NOP with DROP_NOP=1 -> one entry: illegal=1, opsel=`OPSEL_NONE, operands 0; the NOP produces no out_valid.
REQ-040 Fill the queue, assert rst_n=0 mid-stream -> out_valid=0 and decoded_cnt=0 without waiting for a clock edge; after release, the next ADD is the only entry delivered.
REQ-041 CNT_W=4: 17 pops -> decoded_cnt=1.

Source files
------------

// File: rtl/decoder_pipe.sv
// Instruction decoder feeding a small FIFO of decoded ALU operations.
// The head entry is shown combinationally; the last popped entry is held while the queue is empty.
`ifndef INSTRUCTION_NOP
`define INSTRUCTION_NOP 16'h0000
`define INSTRUCTION_AND 16'h0001
`define INSTRUCTION_OR  16'h0002
`define INSTRUCTION_XOR 16'h0003
`define INSTRUCTION_ADD 16'h0004
`define INSTRUCTION_SUB 16'h0005
`define INSTRUCTION_NEG 16'h0006
`endif

`ifndef OPSEL_NONE
`define OPSEL_NONE 3'd0
`define OPSEL_AND  3'd1
`define OPSEL_OR   3'd2
`define OPSEL_XOR  3'd3
`define OPSEL_ADD  3'd4
`define OPSEL_SUB  3'd5
`define OPSEL_NEG  3'd6
`endif

module decoder_pipe #(
  parameter int DATA_W   = 32,
  parameter int SIGN_EXT = 0,
  parameter int DEPTH    = 2,
  parameter int DROP_NOP = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [2:0]        opsel,
  output logic              illegal,
  output logic [CNT_W-1:0]  decoded_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam int EW = 2 * DATA_W + 4;

  logic [15:0]       opcode;
  logic [7:0]        a_field;
  logic [7:0]        b_field;
  logic [DATA_W-1:0] ext_a;
  logic [DATA_W-1:0] ext_b;

  assign opcode  = instruction[31:16];
  assign a_field = instruction[15:8];
  assign b_field = instruction[7:0];

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_ext
      if (gi < 8) begin : g_low
        assign ext_a[gi] = a_field[gi];
        assign ext_b[gi] = b_field[gi];
      end else if (SIGN_EXT != 0) begin : g_sign
        assign ext_a[gi] = a_field[7];
        assign ext_b[gi] = b_field[7];
      end else begin : g_zero
        assign ext_a[gi] = 1'b0;
        assign ext_b[gi] = 1'b0;
      end
    end
  endgenerate

  logic [DATA_W-1:0] dec_op1;
  logic [DATA_W-1:0] dec_op2;
  logic [2:0]        dec_opsel;
  logic              dec_illegal;
  logic              dec_nop;

  always_comb begin
    dec_op1     = '0;
    dec_op2     = '0;
    dec_opsel   = `OPSEL_NONE;
    dec_illegal = 1'b0;
    dec_nop     = 1'b0;
    case (opcode)
      `INSTRUCTION_AND: begin dec_op1 = ext_a; dec_op2 = ext_b; dec_opsel = `OPSEL_AND; end
      `INSTRUCTION_OR:  begin dec_op1 = ext_a; dec_op2 = ext_b; dec_opsel = `OPSEL_OR;  end
      `INSTRUCTION_XOR: begin dec_op1 = ext_a; dec_op2 = ext_b; dec_opsel = `OPSEL_XOR; end
      `INSTRUCTION_ADD: begin dec_op1 = ext_a; dec_op2 = ext_b; dec_opsel = `OPSEL_ADD; end
      `INSTRUCTION_SUB: begin dec_op1 = ext_a; dec_op2 = ext_b; dec_opsel = `OPSEL_SUB; end
      `INSTRUCTION_NEG: begin dec_op1 = ext_a; dec_opsel = `OPSEL_NEG; end
      `INSTRUCTION_NOP: dec_nop = 1'b1;
      default:          dec_illegal = 1'b1;
    endcase
  end

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [OW-1:0]    count_reg;
  logic             ready_en_reg;
  logic [EW-1:0]    hold_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             full;
  logic             push;
  logic             pop;
  logic [EW-1:0]    entry;
  logic [EW-1:0]    head;
  logic [EW-1:0]    view;

  assign full      = (count_reg == OW'(DEPTH));
  assign in_ready  = ready_en_reg & ~full;
  assign out_valid = (count_reg != '0);
  // A dropped NOP still completes the input handshake; it just never enters the queue.
  assign push      = in_valid & in_ready & ~(dec_nop & (DROP_NOP != 0));
  assign pop       = out_valid & out_ready;
  assign entry     = {dec_illegal, dec_opsel, dec_op2, dec_op1};
  assign head      = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      ready_en_reg <= 1'b0;
      hold_reg     <= '0;
      cnt_reg      <= '0;
    end else begin
      ready_en_reg <= 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
        hold_reg   <= head;
        cnt_reg    <= cnt_reg + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + OW'(1);
        2'b01:   count_reg <= count_reg - OW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Memory is only looked at while occupied, so stale or unwritten slots never reach the outputs.
  assign view        = out_valid ? head : hold_reg;
  assign op1         = view[DATA_W-1:0];
  assign op2         = view[2*DATA_W-1:DATA_W];
  assign opsel       = view[2*DATA_W+2:2*DATA_W];
  assign illegal     = view[EW-1];
  assign decoded_cnt = cnt_reg;

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed bench for decoder_pipe: a default instance and a sign-extending,
// NOP-keeping, 4-bit-counter instance, each checked against hand-computed values.
module tb_decoder_pipe;

  localparam logic [15:0] OP_NOP = 16'h0000;
  localparam logic [15:0] OP_ADD = 16'h0004;
  localparam logic [15:0] OP_SUB = 16'h0005;
  localparam logic [15:0] OP_NEG = 16'h0006;
  localparam logic [2:0]  SEL_NONE = 3'd0;
  localparam logic [2:0]  SEL_ADD  = 3'd4;
  localparam logic [2:0]  SEL_SUB  = 3'd5;
  localparam logic [2:0]  SEL_NEG  = 3'd6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid0, in_ready0, out_valid0, out_ready0, illegal0;
  logic [31:0] instr0, op1_0, op2_0;
  logic [2:0]  opsel0;
  logic [15:0] cnt0;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, illegal1;
  logic [31:0] instr1, op1_1, op2_1;
  logic [2:0]  opsel1;
  logic [3:0]  cnt1;

  decoder_pipe u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid0), .in_ready(in_ready0), .instruction(instr0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .op1(op1_0), .op2(op2_0), .opsel(opsel0), .illegal(illegal0),
    .decoded_cnt(cnt0)
  );

  decoder_pipe #(.DATA_W(32), .SIGN_EXT(1), .DEPTH(4), .DROP_NOP(0), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .instruction(instr1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .op1(op1_1), .op2(op2_1), .opsel(opsel1), .illegal(illegal1),
    .decoded_cnt(cnt1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    in_valid0 = 1'b0; out_ready0 = 1'b0; instr0 = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; instr1 = '0;
    #2;
    chk("rst_in_ready", 64'(in_ready0), 64'd0);
    chk("rst_out_valid", 64'(out_valid0), 64'd0);
    chk("rst_op1", 64'(op1_0), 64'd0);
    chk("rst_op2", 64'(op2_0), 64'd0);
    chk("rst_opsel", 64'(opsel0), 64'(SEL_NONE));
    chk("rst_illegal", 64'(illegal0), 64'd0);
    chk("rst_cnt", 64'(cnt0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ready_rise", 64'(in_ready0), 64'd1);

    // Single ADD, consumer ready
    instr0 = {OP_ADD, 8'h12, 8'h34}; in_valid0 = 1'b1; out_ready0 = 1'b1;
    step();
    in_valid0 = 1'b0;
    chk("add_valid", 64'(out_valid0), 64'd1);
    chk("add_op1", 64'(op1_0), 64'h12);
    chk("add_op2", 64'(op2_0), 64'h34);
    chk("add_opsel", 64'(opsel0), 64'(SEL_ADD));
    step();
    chk("add_cnt", 64'(cnt0), 64'd1);
    chk("add_drained", 64'(out_valid0), 64'd0);
    chk("hold_op1", 64'(op1_0), 64'h12);

    // Backpressure on a two-entry queue
    out_ready0 = 1'b0;
    instr0 = {OP_ADD, 8'h01, 8'h01}; in_valid0 = 1'b1;
    step();
    chk("bp_ready1", 64'(in_ready0), 64'd1);
    instr0 = {OP_ADD, 8'h02, 8'h02};
    step();
    chk("bp_full", 64'(in_ready0), 64'd0);
    instr0 = {OP_ADD, 8'h03, 8'h03};
    step();
    chk("bp_stall", 64'(in_ready0), 64'd0);
    chk("bp_head1", 64'(op1_0), 64'h01);
    out_ready0 = 1'b1;
    step();
    chk("bp_head2", 64'(op1_0), 64'h02);
    chk("bp_reopen", 64'(in_ready0), 64'd1);
    chk("bp_cnt2", 64'(cnt0), 64'd2);
    step();
    in_valid0 = 1'b0;
    chk("bp_head3", 64'(op1_0), 64'h03);
    chk("bp_pushpop", 64'(out_valid0), 64'd1);
    chk("bp_cnt3", 64'(cnt0), 64'd3);
    step();
    chk("bp_empty", 64'(out_valid0), 64'd0);
    chk("bp_cnt4", 64'(cnt0), 64'd4);

    // Illegal opcode followed by a dropped NOP
    out_ready0 = 1'b0;
    instr0 = {16'hFFFF, 8'h01, 8'h02}; in_valid0 = 1'b1;
    step();
    instr0 = {OP_NOP, 8'h55, 8'h66};
    step();
    in_valid0 = 1'b0;
    chk("ill_illegal", 64'(illegal0), 64'd1);
    chk("ill_opsel", 64'(opsel0), 64'(SEL_NONE));
    chk("ill_op1", 64'(op1_0), 64'd0);
    chk("ill_op2", 64'(op2_0), 64'd0);
    out_ready0 = 1'b1;
    step();
    chk("nop_dropped", 64'(out_valid0), 64'd0);
    chk("ill_cnt", 64'(cnt0), 64'd5);

    // Mid-stream reset with a full queue
    out_ready0 = 1'b0;
    instr0 = {OP_ADD, 8'h07, 8'h07}; in_valid0 = 1'b1;
    step();
    instr0 = {OP_ADD, 8'h08, 8'h08};
    step();
    in_valid0 = 1'b0;
    chk("pre_rst_full", 64'(in_ready0), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(out_valid0), 64'd0);
    chk("mrst_cnt", 64'(cnt0), 64'd0);
    chk("mrst_ready", 64'(in_ready0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    instr0 = {OP_ADD, 8'h21, 8'h22}; in_valid0 = 1'b1; out_ready0 = 1'b1;
    step();
    in_valid0 = 1'b0;
    chk("post_op1", 64'(op1_0), 64'h21);
    chk("post_valid", 64'(out_valid0), 64'd1);
    step();
    chk("post_empty", 64'(out_valid0), 64'd0);
    chk("post_cnt", 64'(cnt0), 64'd1);

    // Sign extension, kept NOP and 4-bit counter wrap
    instr1 = {OP_SUB, 8'h80, 8'h7F}; in_valid1 = 1'b1;
    step();
    instr1 = {OP_NEG, 8'hFF, 8'h12};
    step();
    instr1 = {OP_NOP, 8'hAA, 8'hBB};
    step();
    in_valid1 = 1'b0;
    chk("sx_sub_op1", 64'(op1_1), 64'hFFFFFF80);
    chk("sx_sub_op2", 64'(op2_1), 64'h0000007F);
    chk("sx_sub_sel", 64'(opsel1), 64'(SEL_SUB));
    out_ready1 = 1'b1;
    step();
    chk("sx_neg_op1", 64'(op1_1), 64'hFFFFFFFF);
    chk("sx_neg_op2", 64'(op2_1), 64'd0);
    chk("sx_neg_sel", 64'(opsel1), 64'(SEL_NEG));
    step();
    chk("nop_kept", 64'(out_valid1), 64'd1);
    chk("nop_sel", 64'(opsel1), 64'(SEL_NONE));
    chk("nop_illegal", 64'(illegal1), 64'd0);
    chk("nop_op1", 64'(op1_1), 64'd0);
    step();
    chk("sx_cnt3", 64'(cnt1), 64'd3);
    instr1 = {OP_ADD, 8'h05, 8'h06}; in_valid1 = 1'b1;
    for (int i = 0; i < 15; i++) step();
    in_valid1 = 1'b0;
    chk("wrap_cnt", 64'(cnt1), 64'd1);
    chk("wrap_valid", 64'(out_valid1), 64'd1);
    step();
    chk("wrap_cnt2", 64'(cnt1), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
